// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared constants and sizing helper for the push-button debounce bank.
//   DEFAULT_STABLE_CYCLES : 10 ms of stability at 50 MHz
//   DEFAULT_REPEAT_DELAY  : 500 ms from press to first auto-repeat at 50 MHz
//   DEFAULT_REPEAT_PERIOD : 100 ms between auto-repeats at 50 MHz
//   cnt_width_f(n)        : bits needed to count 0..n-1, never less than 1
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_DELAY  = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD = 5000000;

    function automatic int cnt_width_f(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button: 2-flop synchroniser, polarity normalisation, stability counter,
// debounced level and registered press/release strobes.
// Optional hold-to-repeat is built when DEBOUNCE_AUTOREPEAT_EN is defined.
//
// Ports:
//   clock_i    system clock
//   reset_i    synchronous active-high reset
//   button_i   raw asynchronous pin level
//   level_o    debounced state, 1 = pressed
//   press_o    one-cycle strobe on accepted press (and repeats, if built)
//   release_o  one-cycle strobe on accepted release
// -----------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int ACTIVE_LOW    = 1
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
`endif
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic button_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int            CW       = cnt_width_f(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    // Pin level when the key is not pressed; also the XOR mask that maps the
    // synchronised pin onto "1 = pressed".
    localparam logic          IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          sync1_q, sync2_q;
    logic          pressed_now;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          rpt_fire;

    assign pressed_now = sync2_q ^ IDLE_PIN;

    // Any sample equal to the current level restarts the count, so only an
    // uninterrupted run of STABLE_CYCLES differing samples flips the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (pressed_now != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d   = (level_d & ~level_q) | rpt_fire;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q   <= IDLE_PIN;
            sync2_q   <= IDLE_PIN;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= button_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int            RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                         : REPEAT_PERIOD;
    localparam int            RW       = cnt_width_f(RPT_MAX);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_first_q, rpt_first_d;

    // Runs only while the level is 1 in both this and the next cycle; the
    // press edge and the release edge both leave it cleared, so a repeat can
    // never coincide with a release.
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        rpt_fire    = 1'b0;
        if (level_q && level_d) begin
            rpt_first_d = rpt_first_q;
            if (rpt_cnt_q == (rpt_first_q ? DLY_LAST : PER_LAST)) begin
                rpt_fire    = 1'b1;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// Multi-channel push-button conditioner: CHANNELS independent copies of
// debounce_channel. Hold-to-repeat is built when DEBOUNCE_AUTOREPEAT_EN is
// defined; otherwise REPEAT_DELAY/REPEAT_PERIOD are only legality-checked.
//
// Ports:
//   clock_i    system clock
//   reset_i    synchronous active-high reset
//   buttons_i  [CHANNELS] raw asynchronous pin levels
//   level_o    [CHANNELS] debounced state, 1 = pressed
//   press_o    [CHANNELS] one-cycle press (and repeat) strobes
//   release_o  [CHANNELS] one-cycle release strobes
// -----------------------------------------------------------------------------
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [CHANNELS-1:0] buttons_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("debounce_bank: CHANNELS must be at least 1");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_bank: STABLE_CYCLES must be at least 2");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY < 1) begin : g_bad_repeat
        $error("debounce_bank: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef DEBOUNCE_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clock_i   (clock_i),
            .reset_i   (reset_i),
            .button_i  (buttons_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
// Scoreboard bench for debounce_bank with CHANNELS=4, STABLE_CYCLES=8,
// ACTIVE_LOW=1. Each stimulus step pushes the strobe event it should cause;
// a negedge monitor pops and compares whenever any strobe is seen.
// Repeat scenarios are included when DEBOUNCE_AUTOREPEAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

    localparam int CH  = 4;
    localparam int SC  = 8;
    localparam int LAT = SC + 2;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn;
    logic [CH-1:0] lvl;
    logic [CH-1:0] prs;
    logic [CH-1:0] rel;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    debounce_bank #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (SC),
        .ACTIVE_LOW    (1),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clock_i   (clk),
        .reset_i   (rst),
        .buttons_i (btn),
        .level_o   (lvl),
        .press_o   (prs),
        .release_o (rel)
    );

    typedef struct {
        int            at;
        logic [CH-1:0] p;
        logic [CH-1:0] r;
        logic [CH-1:0] l;
    } evt_t;

    evt_t          sb_q[$];
    logic [CH-1:0] fut_lvl = '0;
    int            n_chk   = 0;
    int            n_err   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int at, input logic [CH-1:0] p, input logic [CH-1:0] r);
        evt_t e;
        fut_lvl = (fut_lvl | p) & ~r;
        e.at = at;
        e.p  = p;
        e.r  = r;
        e.l  = fut_lvl;
        sb_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every cycle with any strobe must match the next expected event.
    always @(negedge clk) begin
        evt_t e;
        if (prs != '0 || rel != '0) begin
            if (sb_q.size() == 0) begin
                chk("spurious_strobe", {24'h0, prs, rel}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("evt_cycle", cyc, e.at);
                chk("evt_press", prs, e.p);
                chk("evt_release", rel, e.r);
                chk("evt_level", lvl, e.l);
            end
        end
    end

    initial begin
        int c;
        rst = 1'b1;
        btn = '1;
        wait_cycles(3);
        chk("rst_level", lvl, 0);
        chk("rst_press", prs, 0);
        chk("rst_release", rel, 0);
        rst = 1'b0;
        wait_cycles(5);

        // Clean press and release on channel 0.
        btn[0] = 1'b0;
        expect_evt(cyc + LAT, 4'b0001, 4'b0000);
        wait_cycles(20);
        chk("hold_level0", lvl, 4'b0001);
        btn[0] = 1'b1;
        expect_evt(cyc + LAT, 4'b0000, 4'b0001);
        wait_cycles(20);

        // Bounce on channel 1: 3-cycle low/high phases, then a stable low.
        for (int i = 0; i < 10; i++) begin
            btn[1] = (i % 2 == 1);
            wait_cycles(3);
        end
        btn[1] = 1'b0;
        expect_evt(cyc + LAT, 4'b0010, 4'b0000);
        wait_cycles(20);
        btn[1] = 1'b1;
        expect_evt(cyc + LAT, 4'b0000, 4'b0010);
        wait_cycles(20);

        // Glitch on channel 2 one cycle shorter than the stability window.
        btn[2] = 1'b0;
        wait_cycles(SC - 1);
        btn[2] = 1'b1;
        wait_cycles(20);
        chk("glitch_level", lvl, 0);

        // All channels pressed together, released 50 cycles later.
        btn = '0;
        c = cyc;
        expect_evt(c + LAT, 4'b1111, 4'b0000);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        for (int k = LAT + RD; k < LAT + 50; k += RP) begin
            expect_evt(c + k, 4'b1111, 4'b0000);
        end
`endif
        wait_cycles(50);
        btn = '1;
        expect_evt(cyc + LAT, 4'b0000, 4'b1111);
        wait_cycles(20);

        // Reset while channel 3 is mid-count; the press restarts afterwards.
        btn[3] = 1'b0;
        wait_cycles(7);
        rst = 1'b1;
        wait_cycles(1);
        chk("rstcyc_press", prs, 0);
        chk("rstcyc_level", lvl, 0);
        rst = 1'b0;
        expect_evt(cyc + LAT, 4'b1000, 4'b0000);
        wait_cycles(20);
        btn[3] = 1'b1;
        expect_evt(cyc + LAT, 4'b0000, 4'b1000);
        wait_cycles(20);

`ifdef DEBOUNCE_AUTOREPEAT_EN
        // Hold-to-repeat: release accepted 40 cycles after the press, which
        // is also where the next repeat would have fallen.
        btn[0] = 1'b0;
        c = cyc;
        expect_evt(c + LAT, 4'b0001, 4'b0000);
        for (int k = RD; k < 40; k += RP) begin
            expect_evt(c + LAT + k, 4'b0001, 4'b0000);
        end
        wait_cycles(40);
        btn[0] = 1'b1;
        expect_evt(cyc + LAT, 4'b0000, 4'b0001);
        wait_cycles(30);
`endif

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("sb_drain", sb_q.size(), 0);
        chk("final_level", lvl, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
